// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response bus between core and data memory responder
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data memory responder with fixed response latency
module dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input logic             clk,
   input logic             rst,
   dmem_responder_if.slave bus
);
   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        err_q, err_d;
   logic [31:0] rdata_q, rdata_d;

   logic [31:0] mem [DEPTH_WORDS];

   logic [31:0]   word_addr;
   logic          addr_err;
   logic [AW-1:0] idx;
   logic          accept;

   assign word_addr = {2'b00, bus.req_addr[31:2]};
   assign addr_err  = (bus.req_addr[1:0] != 2'b00) || (word_addr >= 32'(DEPTH_WORDS));
   assign idx       = word_addr[AW-1:0];
   assign accept    = bus.req_valid && (state_q == S_IDLE);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               err_d   = addr_err;
               // read data is snapshotted here so later writes cannot disturb the response
               rdata_d = (!bus.req_we && !addr_err) ? mem[idx] : 32'h0;
               if (LATENCY == 0) begin
                  state_d = S_RESP;
                  cnt_d   = 4'd0;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = 4'(LATENCY - 1);
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            if (bus.rsp_ready) begin
               state_d = S_IDLE;
               err_d   = 1'b0;
               rdata_d = 32'h0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         err_q   <= 1'b0;
         rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   // Storage is deliberately outside the reset domain; writes commit at acceptance.
   always_ff @(posedge clk) begin
      if (accept && !rst && bus.req_we && !addr_err) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.req_be[b]) begin
               mem[idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
            end
         end
      end
   end

   assign bus.req_ready = (state_q == S_IDLE);
   assign bus.rsp_valid = (state_q == S_RESP);
   assign bus.rsp_rdata = (state_q == S_RESP) ? rdata_q : 32'h0;
   assign bus.rsp_err   = (state_q == S_RESP) ? err_q : 1'b0;
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized and directed checks of dmem_responder against a word-array model
module tb_dmem_responder;
   localparam int DEPTH  = 1024;
   localparam int LAT    = 2;
   localparam int DEPTH0 = 64;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dmem_responder_if bus ();
   dmem_responder_if bus0 ();

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .bus(bus.slave)
   );
   dmem_responder #(.DEPTH_WORDS(DEPTH0), .LATENCY(0)) dut0 (
      .clk(clk), .rst(rst), .bus(bus0.slave)
   );

   int n_checks = 0;
   int n_err    = 0;
   logic [31:0] model [int];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic is_err(input logic [31:0] a, input int depth);
      return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(depth));
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old_w;
      for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
      return r;
   endfunction

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
   task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input int hold);
      logic [31:0] exp_rd;
      logic        exp_err;
      int          c;
      int          key;
      exp_err = is_err(addr, DEPTH);
      exp_rd  = 32'h0;
      key     = int'(addr >> 2);
      if (!exp_err) begin
         if (we) model[key] = merge(model.exists(key) ? model[key] : 32'h0, wdata, be);
         else    exp_rd = model.exists(key) ? model[key] : 32'hx;
      end
      chk("req_ready_idle", {31'b0, bus.req_ready}, 32'd1);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.req_be    = be;
      bus.rsp_ready = 1'b0;
      @(negedge clk);
      c = 1;
      while (!bus.rsp_valid && c < 40) begin
         @(negedge clk);
         c++;
      end
      chk("latency", 32'(c), 32'(LAT + 1));
      chk("rsp_rdata", bus.rsp_rdata, exp_rd);
      chk("rsp_err", {31'b0, bus.rsp_err}, {31'b0, exp_err});
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_valid", {31'b0, bus.rsp_valid}, 32'd1);
         chk("hold_rdata", bus.rsp_rdata, exp_rd);
         chk("hold_err", {31'b0, bus.rsp_err}, {31'b0, exp_err});
         chk("hold_req_ready", {31'b0, bus.req_ready}, 32'd0);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b0;
      chk("done_valid", {31'b0, bus.rsp_valid}, 32'd0);
      chk("done_req_ready", {31'b0, bus.req_ready}, 32'd1);
      chk("done_rdata", bus.rsp_rdata, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      int          sel;
      int          rdy_cnt;
      int          vld_cnt;

      rst = 1'b1;
      bus.req_valid = 1'b0;  bus.req_we = 1'b0;  bus.req_addr = 32'h0;
      bus.req_wdata = 32'h0; bus.req_be = 4'h0;  bus.rsp_ready = 1'b0;
      bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = 32'h0;
      bus0.req_wdata = 32'h0; bus0.req_be = 4'h0; bus0.rsp_ready = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
      chk("rst_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
      chk("rst0_rsp_valid", {31'b0, bus0.rsp_valid}, 32'd0);
      rst = 1'b0;

      // first request lands on the first edge after reset release
      txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
      txn(1'b0, 32'h10, 32'h0, 4'h0, 0);

      txn(1'b1, 32'h20, 32'h11223344, 4'hF, 0);
      txn(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0);
      txn(1'b0, 32'h20, 32'h0, 4'h0, 0);
      chk("lane_merge_model", model[8], 32'h11BB33DD);
      txn(1'b1, 32'h20, 32'h55667788, 4'h0, 0);
      txn(1'b0, 32'h20, 32'h0, 4'h0, 1);

      for (int w = 0; w < 16; w++) begin
         if (w != 4 && w != 8) txn(1'b1, 32'(w * 4), $urandom, 4'hF, 0);
      end

      txn(1'b0, 32'h22, 32'h0, 4'h0, 0);
      txn(1'b1, 32'(4 * DEPTH), 32'hCAFEF00D, 4'hF, 0);
      txn(1'b0, 32'h0, 32'h0, 4'h0, 0);

      txn(1'b0, 32'h10, 32'h0, 4'h0, 5);

      for (int i = 0; i < 24; i++) begin
         sel = $urandom_range(0, 9);
         if (sel < 7)       a = 32'($urandom_range(0, 15) * 4);
         else if (sel == 7) a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
         else if (sel == 8) a = 32'($urandom_range(DEPTH, DEPTH + 100) * 4);
         else               a = 32'hFFFF_FFFC;
         txn($urandom_range(0, 1) == 1, a, $urandom, 4'($urandom_range(0, 15)),
             $urandom_range(0, 3));
      end

      // reset during WAIT drops the response but keeps the committed write
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h30;
      bus.req_wdata = 32'h0BADF00D; bus.req_be = 4'hF;
      model[12] = 32'h0BADF00D;
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk("wait_no_valid", {31'b0, bus.rsp_valid}, 32'd0);
      rst = 1'b1;
      #1;
      chk("midrst_valid", {31'b0, bus.rsp_valid}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_req_ready", {31'b0, bus.req_ready}, 32'd1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("postrst_valid", {31'b0, bus.rsp_valid}, 32'd0);
      end
      txn(1'b0, 32'h30, 32'h0, 4'h0, 0);

      // zero-latency instance: response visible right after the acceptance edge
      bus0.req_valid = 1'b1; bus0.req_we = 1'b1; bus0.req_addr = 32'h8;
      bus0.req_wdata = 32'h12345678; bus0.req_be = 4'hF; bus0.rsp_ready = 1'b0;
      @(negedge clk);
      chk("l0_valid", {31'b0, bus0.rsp_valid}, 32'd1);
      chk("l0_err", {31'b0, bus0.rsp_err}, 32'd0);
      chk("l0_rdata_wr", bus0.rsp_rdata, 32'h0);
      bus0.req_we = 1'b0;
      bus0.rsp_ready = 1'b1;
      @(negedge clk);
      rdy_cnt = 0;
      vld_cnt = 0;
      for (int k = 0; k < 12; k++) begin
         if (bus0.req_ready) rdy_cnt++;
         if (bus0.rsp_valid) begin
            vld_cnt++;
            chk("l0_rdata_rd", bus0.rsp_rdata, 32'h12345678);
         end
         @(negedge clk);
      end
      bus0.req_valid = 1'b0;
      bus0.rsp_ready = 1'b0;
      chk("l0_accepts", 32'(rdy_cnt), 32'd6);
      chk("l0_responses", 32'(vld_cnt), 32'd6);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
